// File: rtl/param_shift_register_if.sv
// Control/data bundle for param_shift_register: the master drives op, data and start;
// the slave returns the register word, serial output and sequencer status.
interface param_shift_register_if #(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = 4
);
    logic               en;
    logic [2:0]         op;
    logic [WIDTH-1:0]   d;
    logic               ser_in;
    logic               start;
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   q;
    logic               ser_out;
    logic               busy;
    logic               done;

    modport master (
        output en, op, d, ser_in, start, shamt,
        input  q, ser_out, busy, done
    );

    modport slave (
        input  en, op, d, ser_in, start, shamt,
        output q, ser_out, busy, done
    );
endinterface

// File: rtl/param_shift_register.sv
// Purpose: WIDTH-bit register with load/clear/single-step shifts and a start/busy/done multi-step shift sequencer.
// Latency: single steps take effect on the next enabled edge; an N-step shift completes N enabled edges after acceptance.
// Backpressure: en=0 freezes all state; while busy, start/op/d/shamt are ignored.
module param_shift_register #(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = 4
) (
    input  logic clk,
    input  logic rst_n,
    param_shift_register_if.slave bus
);
    localparam logic [2:0] OP_HOLD  = 3'b000;
    localparam logic [2:0] OP_LOAD  = 3'b001;
    localparam logic [2:0] OP_SLL   = 3'b010;
    localparam logic [2:0] OP_SRL   = 3'b011;
    localparam logic [2:0] OP_SRA   = 3'b100;
    localparam logic [2:0] OP_ROL   = 3'b101;
    localparam logic [2:0] OP_ROR   = 3'b110;
    localparam logic [2:0] OP_CLEAR = 3'b111;
    localparam logic [SHAMT_W-1:0] CNT_ONE = {{(SHAMT_W-1){1'b0}}, 1'b1};

    typedef enum logic {S_IDLE, S_SHIFT} state_t;

    state_t             r_state;
    logic [2:0]         r_op;
    logic [SHAMT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_q;
    logic               r_ser_out;
    logic               r_busy;
    logic               r_done;

    state_t             w_state_nxt;
    logic [2:0]         w_op_nxt;
    logic [SHAMT_W-1:0] w_cnt_nxt;
    logic [WIDTH-1:0]   w_q_nxt;
    logic               w_so_nxt;
    logic               w_busy_nxt;
    logic               w_done_nxt;
    logic [WIDTH:0]     w_step;

    function automatic logic f_is_shift(input logic [2:0] a_op);
        return (a_op >= OP_SLL) && (a_op <= OP_ROR);
    endfunction

    // Returns {ser_out, q} after one step of a_op; non-shift ops keep ser_out.
    function automatic logic [WIDTH:0] f_step(
        input logic [2:0]       a_op,
        input logic [WIDTH-1:0] a_q,
        input logic [WIDTH-1:0] a_d,
        input logic             a_si,
        input logic             a_so
    );
        logic [WIDTH:0] v_res;
        case (a_op)
            OP_HOLD:  v_res = {a_so, a_q};
            OP_LOAD:  v_res = {a_so, a_d};
            OP_SLL:   v_res = {a_q[WIDTH-1], a_q[WIDTH-2:0], a_si};
            OP_SRL:   v_res = {a_q[0], a_si, a_q[WIDTH-1:1]};
            OP_SRA:   v_res = {a_q[0], a_q[WIDTH-1], a_q[WIDTH-1:1]};
            OP_ROL:   v_res = {a_q[WIDTH-1], a_q[WIDTH-2:0], a_q[WIDTH-1]};
            OP_ROR:   v_res = {a_q[0], a_q[0], a_q[WIDTH-1:1]};
            OP_CLEAR: v_res = {a_so, {WIDTH{1'b0}}};
            default:  v_res = {a_so, a_q};
        endcase
        return v_res;
    endfunction

    always_comb begin
        w_state_nxt = r_state;
        w_op_nxt    = r_op;
        w_cnt_nxt   = r_cnt;
        w_q_nxt     = r_q;
        w_so_nxt    = r_ser_out;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_step      = {r_ser_out, r_q};
        case (r_state)
            S_IDLE: begin
                if (bus.start && f_is_shift(bus.op)) begin
                    // Accepting edge only arms the sequencer; q is untouched.
                    if (bus.shamt != '0) begin
                        w_state_nxt = S_SHIFT;
                        w_op_nxt    = bus.op;
                        w_cnt_nxt   = bus.shamt;
                        w_busy_nxt  = 1'b1;
                    end else begin
                        w_done_nxt  = 1'b1;
                    end
                end else begin
                    w_step   = f_step(bus.op, r_q, bus.d, bus.ser_in, r_ser_out);
                    w_so_nxt = w_step[WIDTH];
                    w_q_nxt  = w_step[WIDTH-1:0];
                end
            end
            S_SHIFT: begin
                w_step    = f_step(r_op, r_q, bus.d, bus.ser_in, r_ser_out);
                w_so_nxt  = w_step[WIDTH];
                w_q_nxt   = w_step[WIDTH-1:0];
                w_cnt_nxt = r_cnt - CNT_ONE;
                if (r_cnt == CNT_ONE) begin
                    w_state_nxt = S_IDLE;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_op      <= OP_HOLD;
            r_cnt     <= '0;
            r_q       <= '0;
            r_ser_out <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else if (bus.en) begin
            r_state   <= w_state_nxt;
            r_op      <= w_op_nxt;
            r_cnt     <= w_cnt_nxt;
            r_q       <= w_q_nxt;
            r_ser_out <= w_so_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
        end
    end

    assign bus.q       = r_q;
    assign bus.ser_out = r_ser_out;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
endmodule

// File: tb/tb_param_shift_register.sv
// Bench for param_shift_register: vector table for single steps plus hand-written multi-cycle sequences.
module tb_param_shift_register;
    localparam logic [2:0] HOLD = 3'b000, LOAD = 3'b001, SLL = 3'b010, SRL = 3'b011;
    localparam logic [2:0] SRA = 3'b100, ROL = 3'b101, ROR = 3'b110, CLR = 3'b111;

    typedef struct {
        string       nm;
        logic        en;
        logic [2:0]  op;
        logic [7:0]  d;
        logic        si;
        logic        start;
        logic [3:0]  shamt;
        logic        chk_q;
        logic [7:0]  q;
        logic        so;
        logic        busy;
        logic        done;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    vec_t sb[$];
    vec_t tbl[13];

    param_shift_register_if #(.WIDTH(8), .SHAMT_W(4)) bus ();

    param_shift_register #(.WIDTH(8), .SHAMT_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic vec_t V(string nm, logic en, logic [2:0] op, logic [7:0] d, logic si,
                               logic st, logic [3:0] sh, logic cq, logic [7:0] q, logic so,
                               logic b, logic dn);
        vec_t v;
        v.nm = nm; v.en = en; v.op = op; v.d = d; v.si = si; v.start = st; v.shamt = sh;
        v.chk_q = cq; v.q = q; v.so = so; v.busy = b; v.done = dn;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h", nm, act, exp);
        end
    endtask

    // Drive one vector, queue its expectation, and compare once the edge has happened.
    task automatic apply(input vec_t v);
        vec_t e;
        bus.en = v.en; bus.op = v.op; bus.d = v.d; bus.ser_in = v.si;
        bus.start = v.start; bus.shamt = v.shamt;
        sb.push_back(v);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 8'h1, 8'h0);
        end else begin
            e = sb.pop_front();
            if (e.chk_q) begin
                chk({e.nm, ".q"}, bus.q, e.q);
                chk({e.nm, ".ser_out"}, {7'd0, bus.ser_out}, {7'd0, e.so});
            end
            chk({e.nm, ".busy"}, {7'd0, bus.busy}, {7'd0, e.busy});
            chk({e.nm, ".done"}, {7'd0, bus.done}, {7'd0, e.done});
        end
    endtask

    task automatic chk_idle_zero(input string nm);
        chk({nm, ".q"}, bus.q, 8'h00);
        chk({nm, ".ser_out"}, {7'd0, bus.ser_out}, 8'h00);
        chk({nm, ".busy"}, {7'd0, bus.busy}, 8'h00);
        chk({nm, ".done"}, {7'd0, bus.done}, 8'h00);
    endtask

    logic [7:0] rol_q[8];
    logic       rol_so[8];

    initial begin
        tbl[0]  = V("t_load81",  1, LOAD, 8'h81, 0, 0, 0, 1, 8'h81, 0, 0, 0);
        tbl[1]  = V("t_sll",     1, SLL,  8'h00, 1, 0, 0, 1, 8'h03, 1, 0, 0);
        tbl[2]  = V("t_sra",     1, SRA,  8'h00, 0, 0, 0, 1, 8'h01, 1, 0, 0);
        tbl[3]  = V("t_ror",     1, ROR,  8'h00, 0, 0, 0, 1, 8'h80, 1, 0, 0);
        tbl[4]  = V("t_srl",     1, SRL,  8'h00, 0, 0, 0, 1, 8'h40, 0, 0, 0);
        tbl[5]  = V("t_hold",    1, HOLD, 8'hEE, 1, 0, 0, 1, 8'h40, 0, 0, 0);
        tbl[6]  = V("t_rol1",    1, ROL,  8'h00, 0, 0, 0, 1, 8'h80, 0, 0, 0);
        tbl[7]  = V("t_rol2",    1, ROL,  8'h00, 0, 0, 0, 1, 8'h01, 1, 0, 0);
        tbl[8]  = V("t_en0",     0, LOAD, 8'h55, 0, 0, 0, 1, 8'h01, 1, 0, 0);
        tbl[9]  = V("t_loadF0",  1, LOAD, 8'hF0, 0, 0, 0, 1, 8'hF0, 1, 0, 0);
        tbl[10] = V("t_clear",   1, CLR,  8'h00, 0, 0, 0, 1, 8'h00, 1, 0, 0);
        tbl[11] = V("t_st_load", 1, LOAD, 8'h3C, 0, 1, 4, 1, 8'h3C, 1, 0, 0);
        tbl[12] = V("t_sll0",    1, SLL,  8'h00, 0, 0, 0, 1, 8'h78, 0, 0, 0);

        rol_q  = '{8'hB4, 8'h69, 8'hD2, 8'hA5, 8'h4B, 8'h96, 8'h2D, 8'h5A};
        rol_so = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

        bus.en = 0; bus.op = HOLD; bus.d = 0; bus.ser_in = 0; bus.start = 0; bus.shamt = 0;
        repeat (2) @(posedge clk);
        #1;
        chk_idle_zero("reset_state");
        #2 rst_n = 1'b1;

        for (int i = 0; i < 13; i++) apply(tbl[i]);

        // Asynchronous reset with no clock edge in between.
        apply(V("ar_loadA5", 1, LOAD, 8'hA5, 0, 0, 0, 1, 8'hA5, 0, 0, 0));
        #3 rst_n = 1'b0;
        #1 chk_idle_zero("async_reset");
        #2 rst_n = 1'b1;

        apply(V("m_load96", 1, LOAD, 8'h96, 0, 0, 0, 1, 8'h96, 0, 0, 0));
        apply(V("m_start",  1, SRA,  8'h00, 0, 1, 3, 1, 8'h96, 0, 1, 0));
        apply(V("m_step1",  1, HOLD, 8'h00, 0, 0, 0, 1, 8'hCB, 0, 1, 0));
        apply(V("m_step2",  1, HOLD, 8'h00, 0, 0, 0, 1, 8'hE5, 1, 1, 0));
        apply(V("m_step3",  1, HOLD, 8'h00, 0, 0, 0, 1, 8'hF2, 1, 0, 1));
        apply(V("m_after",  1, HOLD, 8'h00, 0, 0, 0, 1, 8'hF2, 1, 0, 0));

        apply(V("s_load01", 1, LOAD, 8'h01, 0, 0, 0, 1, 8'h01, 1, 0, 0));
        apply(V("s_start",  1, ROL,  8'h00, 0, 1, 4, 1, 8'h01, 1, 1, 0));
        apply(V("s_ignore", 1, LOAD, 8'hFF, 0, 1, 2, 1, 8'h02, 0, 1, 0));
        apply(V("s_stall1", 0, HOLD, 8'h00, 0, 0, 0, 1, 8'h02, 0, 1, 0));
        apply(V("s_stall2", 0, LOAD, 8'hFF, 0, 1, 1, 1, 8'h02, 0, 1, 0));
        apply(V("s_step3",  1, HOLD, 8'h00, 0, 0, 0, 1, 8'h04, 0, 1, 0));
        apply(V("s_step4",  1, HOLD, 8'h00, 0, 0, 0, 1, 8'h08, 0, 1, 0));
        apply(V("s_done",   1, HOLD, 8'h00, 0, 0, 0, 1, 8'h10, 0, 0, 1));
        apply(V("s_after",  1, HOLD, 8'h00, 0, 0, 0, 1, 8'h10, 0, 0, 0));

        apply(V("z_start",  1, SLL,  8'h00, 1, 1, 0, 1, 8'h10, 0, 0, 1));
        apply(V("z_en0",    0, HOLD, 8'h00, 0, 0, 0, 1, 8'h10, 0, 0, 1));
        apply(V("z_clear",  1, HOLD, 8'h00, 0, 0, 0, 1, 8'h10, 0, 0, 0));

        apply(V("r_load5A", 1, LOAD, 8'h5A, 0, 0, 0, 1, 8'h5A, 0, 0, 0));
        apply(V("r_start",  1, ROL,  8'h00, 0, 1, 8, 1, 8'h5A, 0, 1, 0));
        for (int i = 0; i < 8; i++)
            apply(V($sformatf("r_step%0d", i), 1, HOLD, 8'h00, 0, 0, 0, 1, rol_q[i], rol_so[i],
                    (i != 7), (i == 7)));
        // New start accepted on the edge that clears done.
        apply(V("b2b_start", 1, ROR, 8'h00, 0, 1, 1, 1, 8'h5A, 0, 1, 0));
        apply(V("b2b_done",  1, HOLD, 8'h00, 0, 0, 0, 1, 8'h2D, 0, 0, 1));

        apply(V("a_load96", 1, LOAD, 8'h96, 0, 0, 0, 1, 8'h96, 0, 0, 0));
        apply(V("a_start",  1, SRA,  8'h00, 0, 1, 12, 1, 8'h96, 0, 1, 0));
        for (int i = 0; i < 11; i++)
            apply(V($sformatf("a_busy%0d", i), 1, HOLD, 8'h00, 0, 0, 0, 0, 8'h00, 0, 1, 0));
        apply(V("a_done",   1, HOLD, 8'h00, 0, 0, 0, 1, 8'hFF, 1, 0, 1));

        apply(V("x_loadF0", 1, LOAD, 8'hF0, 0, 0, 0, 1, 8'hF0, 1, 0, 0));
        apply(V("x_start",  1, SRL,  8'h00, 0, 1, 5, 1, 8'hF0, 1, 1, 0));
        apply(V("x_step1",  1, HOLD, 8'h00, 0, 0, 0, 1, 8'h78, 0, 1, 0));
        #3 rst_n = 1'b0;
        #1 chk_idle_zero("mid_seq_reset");
        #2 rst_n = 1'b1;
        for (int i = 0; i < 6; i++)
            apply(V($sformatf("x_post%0d", i), 1, HOLD, 8'h00, 1, 0, 0, 1, 8'h00, 0, 0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/param_shift_register.md
Name: param_shift_register

Overview:
- Parametrised, enabled storage register; successor to the single-bit enabled flip-flop.
- Holds a WIDTH-bit word with synchronous parallel load, clear, and single-step logical, arithmetic and rotate shifts.
- Adds a multi-cycle shift sequencer: a start/busy/done handshake shifts the word by a programmed amount, one bit per enabled cycle.
- Used in the datapath next to the program counter, as the shifter and general-purpose operand register.

Parameters:
- WIDTH, 8, register width in bits; must be ≥ 2.
- SHAMT_W, 4, width of the shift-amount port. Amounts up to 2^SHAMT_W−1 are legal, including amounts ≥ WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  clock enable. When low, no state changes and the sequencer stalls.
- op  input  3  operation code:
  - 000 hold, 001 load, 010 SLL, 011 SRL
  - 100 SRA, 101 ROL, 110 ROR, 111 clear
- d  input  WIDTH  parallel load data.
- ser_in  input  1  fill bit for SLL (into the LSB) and SRL (into the MSB).
- start  input  1  request a multi-step shift of amount shamt using op.
- shamt  input  SHAMT_W  number of single-bit steps for a multi-step shift.
- q  output  WIDTH  register contents.
- ser_out  output  1  last bit shifted or rotated out.
- busy  output  1  multi-step shift in progress.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (async, rst_n=0):
  - q=0, ser_out=0, busy=0, done=0.
  - Sequencer returns to IDLE and the step counter is cleared.
  - Reset asserted mid-sequence aborts the sequence; no done pulse is produced.
- Edge rule: all state updates happen on the rising clk edge, and only when en=1. When en=0, every register holds, and done holds its value.
- Single-step operations (IDLE, start=0, en=1), effect on q at the edge:
  - hold: no change. load: q=d. clear: q=0.
  - SLL: q={q[W-2:0],ser_in}, ser_out=q[W-1].
  - SRL: q={ser_in,q[W-1:1]}, ser_out=q[0].
  - SRA: q={q[W-1],q[W-1:1]}, ser_out=q[0].
  - ROL: q={q[W-2:0],q[W-1]}, ser_out=q[W-1].
  - ROR: q={q[0],q[W-1:1]}, ser_out=q[0].
  - hold, load and clear leave ser_out unchanged.
- Sequencer states:
  - IDLE: accepts single steps and start.
  - SHIFT: executes the latched op once per enabled edge and decrements the counter.
- Start acceptance (IDLE, en=1, start=1):
  - With a shift op (010..110) and shamt≠0: latch op, set count=shamt, set busy=1, go to SHIFT. q is not modified on the accepting edge.
  - With a shift op and shamt=0: stay IDLE, q unchanged, done=1 for one cycle, busy stays 0.
  - With a non-shift op: the op executes as a single step, with no busy and no done.
- In SHIFT, on each en=1 edge:
  - Perform one step of the latched op; ser_in is sampled fresh at each step.
  - Decrement the count.
  - On the edge where the count goes 1→0: busy=0, done=1, return to IDLE.
- Timing: N steps finish N edges after acceptance; done is high for the cycle that follows.
- When en=0 in SHIFT, the sequence stalls with no step, and busy stays 1.
- While busy, start, op, d and shamt are ignored.
- done is cleared on the next en=1 edge. A new start may be accepted on that same edge.
- Amounts ≥ WIDTH are executed literally as that many steps. For example, SRA by 12 on an 8-bit word yields all sign bits, and ROL by WIDTH restores the original value.

Test Plan:
- Reset: drive rst_n=0 mid-cycle with q=0xA5 → q=0, busy=0, done=0 immediately, without waiting for a clk edge.
- Single steps, starting from load d=0x81:
  - SLL with ser_in=1 → q=0x03, ser_out=1.
  - Then SRA → q=0x01, ser_out=1.
  - Then ROR → q=0x80, ser_out=1.
- Multi-step: q=0x96, start with op=SRA, shamt=3, en held high:
  - busy=1 for 3 cycles.
  - Then done pulses exactly one cycle.
  - q=0xF2, ser_out=1.
- Stall and ignore: q=0x01, start with op=ROL, shamt=4:
  - Drop en for 2 cycles mid-sequence, and pulse start with op=load, d=0xFF while busy.
  - Result: q=0x10, done after 6 enabled-plus-stalled cycles, and the load is ignored.
- Boundaries:
  - shamt=0 with op=SLL → done the next cycle, busy never asserted, q unchanged.
  - shamt=8 with op=ROL on 0x5A → q=0x5A after 8 steps.
- Reset mid-sequence: assert rst_n=0 during an SRL by 5 → q=0, busy=0, and no done pulse after release.
